// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU main controller.
//   state_t  : 5-bit controller state encoding (RESET is all-zero so the
//              debug port reads 0 while reset is held)
//   OP_* / FN_*    : instruction opcode and R-type funct codes
//   IORD_*, REGDST_*, DATA_*, SRCA_*, SRCB_*, ALU_*, PCSRC_* : mux/ALU codes
//   ctrl_t   : bundle of every control output driven by the controller
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_IR_LOAD    = 5'd3,
    S_DECODE     = 5'd4,
    S_EXEC_R     = 5'd5,
    S_WB_R       = 5'd6,
    S_EXEC_I     = 5'd7,
    S_WB_I       = 5'd8,
    S_ADDR       = 5'd9,
    S_MEM_RD     = 5'd10,
    S_WB_LW      = 5'd11,
    S_MEM_WR     = 5'd12,
    S_BRANCH     = 5'd13,
    S_JUMP       = 5'd14,
    S_EXC_OVF    = 5'd15,
    S_EXC_OPC    = 5'd16,
    S_EXC_RD     = 5'd17,
    S_EXC_LOAD   = 5'd18
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [1:0] IORD_PC     = 2'd0;
  localparam logic [1:0] IORD_ALUOUT = 2'd1;
  localparam logic [1:0] IORD_EXC    = 2'd2;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_SP = 2'd2;

  localparam logic [1:0] DATA_ALUOUT = 2'd0;
  localparam logic [1:0] DATA_MDR    = 2'd1;
  localparam logic [1:0] DATA_SPINIT = 2'd2;

  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_A  = 1'b1;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd7;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_EXC    = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       a_write;
    logic       b_write;
    logic       epc_write;
    logic [1:0] iord;
    logic [1:0] reg_dst;
    logic [1:0] data_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // True for the R-type functions this controller implements.
  function automatic logic funct_valid(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
  endfunction

  function automatic logic [2:0] funct_aluop(input logic [5:0] fn);
    case (fn)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle main controller (Moore FSM) for the CPU datapath.
// Ports:
//   clock, reset            : rising-edge clock, async active-high reset
//   opcode, funct           : IR[31:26], IR[5:0]
//   zero, overflow          : ALU flags (zero is consumed by the datapath via PCWriteCond)
//   PCWrite..EPCWrite       : register / memory write enables
//   IorD, RegDst, DataSrc, ALUSrcA, ALUSrcB, ALUOp, PCSource : mux and ALU selects
//   state_dbg               : current state encoding
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] SP_INIT    = 32'd227,
  parameter int unsigned MEM_WAIT   = 1,
  parameter logic [31:0] EXC_VECTOR = 32'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       AWrite,
  output logic       BWrite,
  output logic       EPCWrite,
  output logic [1:0] IorD,
  output logic [1:0] RegDst,
  output logic [1:0] DataSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [4:0] state_dbg
);

  // FETCH itself is the first memory-read cycle, so FETCH_WAIT only covers
  // the extra cycles. MEM_RD and EXC_RD hold their address for the read
  // cycle plus the extra wait cycles.
  localparam logic [1:0] C_FW_LAST = 2'((MEM_WAIT == 0) ? 0 : MEM_WAIT - 1);
  localparam logic [1:0] C_RD_LAST = 2'(MEM_WAIT);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_wait_cnt;
  logic       w_wait_entry;
  logic       w_fw_done;
  logic       w_rd_done;
  ctrl_t      w_ctrl;
  ctrl_t      w_ctrl_out;
  logic       w_unused_params;

  // SP_INIT and the exception vector are constants muxed in by the datapath;
  // the zero flag acts through PCWriteCond in the datapath as well.
  assign w_unused_params = ^{SP_INIT, EXC_VECTOR, zero};

  assign w_wait_entry = (w_state_next != r_state) &&
                        (w_state_next inside {S_FETCH_WAIT, S_MEM_RD, S_EXC_RD});
  assign w_fw_done    = (r_wait_cnt >= C_FW_LAST);
  assign w_rd_done    = (r_wait_cnt >= C_RD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_RESET;
      r_wait_cnt <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (w_wait_entry)
        r_wait_cnt <= 2'd0;
      else if (r_wait_cnt != 2'd3)
        r_wait_cnt <= r_wait_cnt + 2'd1;
    end
  end

  always_comb begin
    w_state_next = S_RESET;
    case (r_state)
      S_RESET:      w_state_next = S_FETCH;
      S_FETCH:      w_state_next = (MEM_WAIT == 0) ? S_IR_LOAD : S_FETCH_WAIT;
      S_FETCH_WAIT: w_state_next = w_fw_done ? S_IR_LOAD : S_FETCH_WAIT;
      S_IR_LOAD:    w_state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_state_next = funct_valid(funct) ? S_EXEC_R : S_EXC_OPC;
          OP_ADDI:      w_state_next = S_EXEC_I;
          OP_LW, OP_SW: w_state_next = S_ADDR;
          OP_BEQ:       w_state_next = S_BRANCH;
          OP_J:         w_state_next = S_JUMP;
          default:      w_state_next = S_EXC_OPC;
        endcase
      end
      // AND cannot overflow, so the flag is ignored for it.
      S_EXEC_R: w_state_next = (overflow && (funct == FN_ADD || funct == FN_SUB))
                               ? S_EXC_OVF : S_WB_R;
      S_EXEC_I: w_state_next = overflow ? S_EXC_OVF : S_WB_I;
      S_ADDR:   w_state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: w_state_next = w_rd_done ? S_WB_LW : S_MEM_RD;
      S_EXC_OVF, S_EXC_OPC: w_state_next = S_EXC_RD;
      S_EXC_RD: w_state_next = w_rd_done ? S_EXC_LOAD : S_EXC_RD;
      S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP, S_EXC_LOAD:
        w_state_next = S_FETCH;
      default:  w_state_next = S_RESET;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_RESET: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = REGDST_SP;
        w_ctrl.data_src  = DATA_SPINIT;
      end
      S_FETCH: begin
        w_ctrl.iord      = IORD_PC;
        w_ctrl.alu_src_a = SRCA_PC;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALU_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
        w_ctrl.pc_write  = 1'b1;
      end
      S_IR_LOAD: w_ctrl.ir_write = 1'b1;
      S_DECODE: begin
        w_ctrl.a_write   = 1'b1;
        w_ctrl.b_write   = 1'b1;
        w_ctrl.alu_src_a = SRCA_PC;
        w_ctrl.alu_src_b = SRCB_IMM_SH;
        w_ctrl.alu_op    = ALU_ADD;
      end
      // funct comes from the IR, which is stable for the whole instruction.
      S_EXEC_R: begin
        w_ctrl.alu_src_a = SRCA_A;
        w_ctrl.alu_src_b = SRCB_B;
        w_ctrl.alu_op    = funct_aluop(funct);
      end
      S_WB_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = REGDST_RD;
        w_ctrl.data_src  = DATA_ALUOUT;
      end
      S_EXEC_I, S_ADDR: begin
        w_ctrl.alu_src_a = SRCA_A;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALU_ADD;
      end
      S_WB_I: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = REGDST_RT;
        w_ctrl.data_src  = DATA_ALUOUT;
      end
      S_MEM_RD: w_ctrl.iord = IORD_ALUOUT;
      S_WB_LW: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = REGDST_RT;
        w_ctrl.data_src  = DATA_MDR;
      end
      S_MEM_WR: begin
        w_ctrl.iord      = IORD_ALUOUT;
        w_ctrl.mem_write = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a     = SRCA_A;
        w_ctrl.alu_src_b     = SRCB_B;
        w_ctrl.alu_op        = ALU_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
      end
      // EPC <= PC - 4 (PC was already advanced in FETCH).
      S_EXC_OVF, S_EXC_OPC: begin
        w_ctrl.epc_write = 1'b1;
        w_ctrl.alu_src_a = SRCA_PC;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALU_SUB;
      end
      S_EXC_RD: w_ctrl.iord = IORD_EXC;
      S_EXC_LOAD: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_EXC;
      end
      default: w_ctrl = '0;
    endcase
  end

  // Reset forces every control output low immediately, before any clock edge.
  assign w_ctrl_out = reset ? '0 : w_ctrl;

  assign PCWrite     = w_ctrl_out.pc_write;
  assign PCWriteCond = w_ctrl_out.pc_write_cond;
  assign MemWrite    = w_ctrl_out.mem_write;
  assign IRWrite     = w_ctrl_out.ir_write;
  assign RegWrite    = w_ctrl_out.reg_write;
  assign AWrite      = w_ctrl_out.a_write;
  assign BWrite      = w_ctrl_out.b_write;
  assign EPCWrite    = w_ctrl_out.epc_write;
  assign IorD        = w_ctrl_out.iord;
  assign RegDst      = w_ctrl_out.reg_dst;
  assign DataSrc     = w_ctrl_out.data_src;
  assign ALUSrcA     = w_ctrl_out.alu_src_a;
  assign ALUSrcB     = w_ctrl_out.alu_src_b;
  assign ALUOp       = w_ctrl_out.alu_op;
  assign PCSource    = w_ctrl_out.pc_source;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a per-instruction cycle-by-cycle
// model of expected control words, directed scenarios plus random programs.
module tb_control_unit;

  localparam int MW = 1;

  typedef struct packed {
    logic       pc_w;
    logic       pc_wc;
    logic       mem_w;
    logic       ir_w;
    logic       reg_w;
    logic       a_w;
    logic       b_w;
    logic       epc_w;
    logic [1:0] iord;
    logic [1:0] regdst;
    logic [1:0] datasrc;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
  } ctl_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       overflow = 1'b0;
  logic       PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite, AWrite, BWrite, EPCWrite;
  logic [1:0] IorD, RegDst, DataSrc, ALUSrcB, PCSource;
  logic       ALUSrcA;
  logic [2:0] ALUOp;
  logic [4:0] state_dbg;

  int   n_tests = 0;
  int   n_fail  = 0;
  ctl_t exp_q[$];

  control_unit #(.SP_INIT(32'd227), .MEM_WAIT(MW), .EXC_VECTOR(32'd0)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .AWrite(AWrite), .BWrite(BWrite),
    .EPCWrite(EPCWrite), .IorD(IorD), .RegDst(RegDst), .DataSrc(DataSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t get_ctl();
    ctl_t c;
    c.pc_w = PCWrite;   c.pc_wc = PCWriteCond; c.mem_w = MemWrite; c.ir_w = IRWrite;
    c.reg_w = RegWrite; c.a_w = AWrite;        c.b_w = BWrite;     c.epc_w = EPCWrite;
    c.iord = IorD;      c.regdst = RegDst;     c.datasrc = DataSrc;
    c.srca = ALUSrcA;   c.srcb = ALUSrcB;      c.aluop = ALUOp;    c.pcsrc = PCSource;
    return c;
  endfunction

  // Exception entry: save PC-4, read handler address, load PC from memory byte.
  task automatic model_exc();
    ctl_t c;
    c = '0; c.epc_w = 1; c.srcb = 2'd1; c.aluop = 3'd1; exp_q.push_back(c);
    c = '0; c.iord = 2'd2;
    repeat (MW + 1) exp_q.push_back(c);
    c = '0; c.pc_w = 1; c.pcsrc = 2'd3; exp_q.push_back(c);
  endtask

  // Expected control words, one per cycle, for one whole instruction.
  task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
    ctl_t c;
    exp_q.delete();
    c = '0; c.pc_w = 1; c.srcb = 2'd1; exp_q.push_back(c);
    c = '0;
    repeat (MW) exp_q.push_back(c);
    c = '0; c.ir_w = 1; exp_q.push_back(c);
    c = '0; c.a_w = 1; c.b_w = 1; c.srcb = 2'd3; exp_q.push_back(c);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      c = '0; c.srca = 1;
      c.aluop = (fn == 6'h20) ? 3'd0 : (fn == 6'h22) ? 3'd1 : 3'd2;
      exp_q.push_back(c);
      if (ovf && fn != 6'h24) model_exc();
      else begin c = '0; c.reg_w = 1; c.regdst = 2'd1; exp_q.push_back(c); end
    end else if (op == 6'h08) begin
      c = '0; c.srca = 1; c.srcb = 2'd2; exp_q.push_back(c);
      if (ovf) model_exc();
      else begin c = '0; c.reg_w = 1; exp_q.push_back(c); end
    end else if (op == 6'h23) begin
      c = '0; c.srca = 1; c.srcb = 2'd2; exp_q.push_back(c);
      c = '0; c.iord = 2'd1;
      repeat (MW + 1) exp_q.push_back(c);
      c = '0; c.reg_w = 1; c.datasrc = 2'd1; exp_q.push_back(c);
    end else if (op == 6'h2B) begin
      c = '0; c.srca = 1; c.srcb = 2'd2; exp_q.push_back(c);
      c = '0; c.iord = 2'd1; c.mem_w = 1; exp_q.push_back(c);
    end else if (op == 6'h04) begin
      c = '0; c.srca = 1; c.aluop = 3'd1; c.pc_wc = 1; c.pcsrc = 2'd1; exp_q.push_back(c);
    end else if (op == 6'h02) begin
      c = '0; c.pc_w = 1; c.pcsrc = 2'd2; exp_q.push_back(c);
    end else begin
      model_exc();
    end
  endtask

  task automatic apply_reset(input bit chk);
    ctl_t c;
    reset = 1'b1;
    #1;
    if (chk) begin
      n_tests++;
      if (get_ctl() !== '0) begin
        n_fail++; $display("FAIL reset_async_outputs: got %h required 0", get_ctl());
      end
      n_tests++;
      if (state_dbg !== 5'd0) begin
        n_fail++; $display("FAIL reset_state_dbg: got %0d required 0", state_dbg);
      end
    end
    @(posedge clock); #1;
    if (chk) begin
      n_tests++;
      if (get_ctl() !== '0) begin
        n_fail++; $display("FAIL reset_held_outputs: got %h required 0", get_ctl());
      end
    end
    reset = 1'b0;
    @(negedge clock);
    if (chk) begin
      c = '0; c.reg_w = 1; c.regdst = 2'd2; c.datasrc = 2'd2;
      n_tests++;
      if (get_ctl() !== c) begin
        n_fail++; $display("FAIL reset_sp_write: got %h required %h", get_ctl(), c);
      end
      $display("[TB] reset: outputs low while asserted, SP_INIT write to $29 after release");
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic ovf, input logic zr);
    ctl_t act;
    bit   bad;
    int   n;
    model(op, fn, ovf);
    opcode = op; funct = fn; overflow = ovf; zero = zr;
    bad = 0;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      act = get_ctl();
      n_tests++;
      if (act !== exp_q[k]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h required %h", name, k, act, exp_q[k]);
        bad = 1;
        break;
      end
    end
    $display("[TB] %s op=%h funct=%h ovf=%b zero=%b cycles=%0d %s",
             name, op, fn, ovf, zr, n, bad ? "diverged" : "ok");
    if (bad) apply_reset(1'b0);
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
  endtask

  task automatic test_add();
    run_instr("add", 6'h00, 6'h20, 1'b0, 1'b0);
    run_instr("sub", 6'h00, 6'h22, 1'b0, 1'b0);
  endtask

  task automatic test_and_ovf_ignored();
    run_instr("and_ovf", 6'h00, 6'h24, 1'b1, 1'b0);
  endtask

  task automatic test_addi();
    run_instr("addi", 6'h08, 6'h11, 1'b0, 1'b0);
    run_instr("addi_ovf", 6'h08, 6'h11, 1'b1, 1'b0);
  endtask

  task automatic test_lw_sw();
    run_instr("lw", 6'h23, 6'h05, 1'b0, 1'b0);
    run_instr("sw", 6'h2B, 6'h05, 1'b0, 1'b0);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'h04, 6'h00, 1'b0, 1'b1);
    run_instr("beq_not_taken", 6'h04, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic test_ovf();
    run_instr("add_ovf", 6'h00, 6'h20, 1'b1, 1'b0);
    run_instr("sub_ovf", 6'h00, 6'h22, 1'b1, 1'b0);
  endtask

  task automatic test_invalid();
    run_instr("bad_opcode", 6'h3F, 6'h20, 1'b0, 1'b0);
    run_instr("bad_funct", 6'h00, 6'h2A, 1'b0, 1'b0);
  endtask

  task automatic test_jump();
    run_instr("jump", 6'h02, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_exec();
    ctl_t act;
    model(6'h00, 6'h20, 1'b0);
    opcode = 6'h00; funct = 6'h20; overflow = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      act = get_ctl();
      n_tests++;
      if (act !== exp_q[k]) begin
        n_fail++;
        $display("FAIL mid_exec_prefix cycle %0d: got %h required %h", k, act, exp_q[k]);
      end
    end
    apply_reset(1'b1);
  endtask

  task automatic test_random();
    logic [5:0] op_tab [10] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h00, 6'h00};
    logic [5:0] fn_tab [4]  = '{6'h20, 6'h22, 6'h24, 6'h00};
    logic [5:0] op, fn;
    int sel;
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 10));
      op = (sel == 10) ? 6'($urandom_range(0, 63)) : op_tab[sel];
      sel = int'($urandom_range(0, 3));
      fn = (sel == 3) ? 6'($urandom_range(0, 63)) : fn_tab[sel];
      run_instr("rand", op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_and_ovf_ignored();
    test_addi();
    test_lw_sw();
    test_beq();
    test_ovf();
    test_invalid();
    test_jump();
    test_reset_mid_exec();
    test_add();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
